// File: rtl/control_seq.sv
// Multi-cycle FETCH/EXEC control sequencer for the 8-bit CPU, with registered flags and a retire counter.
// Optional single-step mode (PAUSE state, step input) is enabled by defining CONTROL_SINGLE_STEP_EN.
module control_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int HALT_DEST  = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
`ifdef CONTROL_SINGLE_STEP_EN
  input  logic                  step,
`endif
  input  logic [7:0]            ir,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  alu_carry,
  input  logic                  mem_ready,
  output logic                  load_ir,
  output logic                  load_pc,
  output logic                  load_a,
  output logic                  load_b,
  output logic                  load_x,
  output logic                  load_q,
  output logic                  store_mem,
  output logic                  assert_bar_m,
  output logic                  assert_bar_e,
  output logic                  assert_bar_a,
  output logic                  assert_bar_x,
  output logic                  inc_pc,
  output logic                  immediate,
  output logic                  do_subtract,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] HALT  = 3'd3;
  localparam logic [2:0] PAUSE = 3'd4;

  localparam logic [2:0] HALT_CODE = HALT_DEST[2:0];

  logic [2:0] state;
  logic [2:0] next_state;

  logic       bit7;
  logic       bit6;
  logic [1:0] source;
  logic [2:0] dest;
  logic       indexed;
  logic       is_halt;
  logic       mem_wait;
  logic       gate;
  logic       cond;
  logic       exec_done;

  assign bit7    = ir[7];
  assign bit6    = ir[6];
  assign source  = ir[5:4];
  assign dest    = ir[3:1];
  assign indexed = ir[0];

  assign is_halt  = (dest == HALT_CODE);
  assign mem_wait = (source == 2'd0) || (dest == 3'd5);
  assign gate     = !mem_wait || mem_ready;
  assign cond     = (bit6 & flag_zero) | (bit7 & flag_carry) | (bit6 & bit7);

  // HALT never waits on memory: it drives no strobes, so there is nothing to complete.
  assign exec_done = (state == EXEC) && (is_halt || gate);

  assign halted = (state == HALT);

`ifdef CONTROL_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (run) next_state = FETCH;
      FETCH: if (mem_ready) next_state = EXEC;
      EXEC: begin
        if (is_halt) begin
          next_state = HALT;
        end else if (exec_done) begin
`ifdef CONTROL_SINGLE_STEP_EN
          next_state = PAUSE;
`else
          next_state = FETCH;
`endif
        end
      end
      HALT:  next_state = HALT;
`ifdef CONTROL_SINGLE_STEP_EN
      PAUSE: if (step_rise) next_state = FETCH;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flags only move when an A-write actually completes; carry only from the ALU source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      retired    <= '0;
    end else if (exec_done) begin
      retired <= retired + 1'b1;
      if (load_a) begin
        flag_zero <= (bus == '0);
        if (source == 2'd1) flag_carry <= alu_carry;
      end
    end
  end

  always_comb begin
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_x       = 1'b0;
    load_q       = 1'b0;
    store_mem    = 1'b0;
    assert_bar_m = 1'b1;
    assert_bar_e = 1'b1;
    assert_bar_a = 1'b1;
    assert_bar_x = 1'b1;
    inc_pc       = 1'b0;
    immediate    = 1'b0;
    do_subtract  = 1'b0;
    case (state)
      FETCH: begin
        assert_bar_m = 1'b0;
        load_ir      = mem_ready;
        inc_pc       = mem_ready;
      end
      EXEC: begin
        assert_bar_m = ~(source == 2'd0);
        assert_bar_e = ~(source == 2'd1);
        assert_bar_a = ~(source == 2'd2);
        assert_bar_x = ~(source == 2'd3);
        immediate    = ~indexed;
        do_subtract  = bit6;
        if (!is_halt && gate) begin
          load_ir   = (dest == 3'd0);
          load_pc   = (dest == 3'd1) & cond;
          load_a    = (dest == 3'd2);
          load_x    = (dest == 3'd3);
          load_b    = (dest == 3'd4);
          store_mem = (dest == 3'd5);
          load_q    = (dest == 3'd6);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_seq.sv
// Directed scoreboard bench for control_seq; expected output snapshots are queued per cycle and checked at negedge.
module tb_control_seq;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [7:0]  ir;
  logic [7:0]  bus;
  logic        alu_carry;
  logic        mem_ready;
  logic        load_ir, load_pc, load_a, load_b, load_x, load_q, store_mem;
  logic        assert_bar_m, assert_bar_e, assert_bar_a, assert_bar_x;
  logic        inc_pc, immediate, do_subtract;
  logic        flag_zero, flag_carry, halted;
  logic [15:0] retired;
`ifdef CONTROL_SINGLE_STEP_EN
  logic        step;
`endif

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    string       tag;
    logic [32:0] val;
  } exp_t;

  exp_t sb[$];

  control_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
`ifdef CONTROL_SINGLE_STEP_EN
    .step         (step),
`endif
    .ir           (ir),
    .bus          (bus),
    .alu_carry    (alu_carry),
    .mem_ready    (mem_ready),
    .load_ir      (load_ir),
    .load_pc      (load_pc),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_x       (load_x),
    .load_q       (load_q),
    .store_mem    (store_mem),
    .assert_bar_m (assert_bar_m),
    .assert_bar_e (assert_bar_e),
    .assert_bar_a (assert_bar_a),
    .assert_bar_x (assert_bar_x),
    .inc_pc       (inc_pc),
    .immediate    (immediate),
    .do_subtract  (do_subtract),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control field order: ir pc a b x q st | bm be ba bx | inc imm sub
  localparam logic [13:0] C_IDLE   = 14'b0000000_1111_000;
  localparam logic [13:0] C_FETCH  = 14'b1000000_0111_100;
  localparam logic [13:0] C_FWAIT  = 14'b0000000_0111_000;

  function automatic logic [32:0] observed();
    return {load_ir, load_pc, load_a, load_b, load_x, load_q, store_mem,
            assert_bar_m, assert_bar_e, assert_bar_a, assert_bar_x,
            inc_pc, immediate, do_subtract,
            flag_zero, flag_carry, halted, retired};
  endfunction

  task automatic push_exp(input string tag, input logic [13:0] ctl, input logic fz,
                          input logic fc, input logic h, input logic [15:0] ret);
    exp_t e;
    e.tag = tag;
    e.val = {ctl, fz, fc, h, ret};
    sb.push_back(e);
  endtask

  task automatic check_head();
    exp_t        e;
    logic [32:0] obs;
    e   = sb.pop_front();
    obs = observed();
    assertions++;
    assert (obs === e.val) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b required %b", e.tag, obs, e.val);
    end
  endtask

  // One clock cycle: inputs already driven just after the posedge, checked at the negedge.
  task automatic cyc(input string tag, input logic [13:0] ctl, input logic fz,
                     input logic fc, input logic h, input logic [15:0] ret);
    push_exp(tag, ctl, fz, fc, h, ret);
    @(negedge clk);
    check_head();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [13:0] ctl, input logic fz,
                           input logic fc, input logic h, input logic [15:0] ret);
    push_exp(tag, ctl, fz, fc, h, ret);
    #1;
    check_head();
  endtask

  initial begin
    reset_n   = 1'b1;
    run       = 1'b0;
    ir        = 8'h00;
    bus       = 8'h00;
    alu_carry = 1'b0;
    mem_ready = 1'b0;
`ifdef CONTROL_SINGLE_STEP_EN
    step      = 1'b0;
`endif
    #1 reset_n = 1'b0;
    check_now("reset", C_IDLE, 0, 0, 0, 16'd0);

    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;

`ifndef CONTROL_SINGLE_STEP_EN
    ir = 8'h12;
    cyc("idle", C_IDLE, 0, 0, 0, 16'd0);
    cyc("fetch_12", C_FETCH, 0, 0, 0, 16'd0);
    cyc("exec_12_nojump", 14'b0000000_1011_010, 0, 0, 0, 16'd0);
    ir = 8'h14; bus = 8'h00; alu_carry = 1'b1;
    cyc("fetch_14", C_FETCH, 0, 0, 0, 16'd1);
    cyc("exec_14_load_a", 14'b0010000_1011_010, 0, 0, 0, 16'd1);
    ir = 8'h52; bus = 8'h55; alu_carry = 1'b0;
    cyc("fetch_52_flags", C_FETCH, 1, 1, 0, 16'd2);
    cyc("exec_52_jump", 14'b0100000_1011_011, 1, 1, 0, 16'd2);
    ir = 8'h2A; mem_ready = 1'b0;
    cyc("fetch_wait1", C_FWAIT, 1, 1, 0, 16'd3);
    cyc("fetch_wait2", C_FWAIT, 1, 1, 0, 16'd3);
    cyc("fetch_wait3", C_FWAIT, 1, 1, 0, 16'd3);
    mem_ready = 1'b1;
    cyc("fetch_ready", C_FETCH, 1, 1, 0, 16'd3);
    mem_ready = 1'b0;
    cyc("exec_2a_wait", 14'b0000000_1101_010, 1, 1, 0, 16'd3);
    mem_ready = 1'b1;
    cyc("exec_2a_store", 14'b0000001_1101_010, 1, 1, 0, 16'd3);
    ir = 8'h24; bus = 8'h01; alu_carry = 1'b0;
    cyc("fetch_24", C_FETCH, 1, 1, 0, 16'd4);
    cyc("exec_24_load_a", 14'b0010000_1101_010, 1, 1, 0, 16'd4);
    ir = 8'h0E; bus = 8'h00;
    cyc("fetch_0e_carry_kept", C_FETCH, 0, 1, 0, 16'd5);
    cyc("exec_0e_halt", 14'b0000000_0111_010, 0, 1, 0, 16'd5);
    run = 1'b0; mem_ready = 1'b0;
    cyc("halt1", C_IDLE, 0, 1, 1, 16'd6);
    run = 1'b1; mem_ready = 1'b1;
    cyc("halt2", C_IDLE, 0, 1, 1, 16'd6);
    run = 1'b0;
    cyc("halt3", C_IDLE, 0, 1, 1, 16'd6);
    reset_n = 1'b0;
    check_now("halt_async_reset", C_IDLE, 0, 0, 0, 16'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("idle_after_reset", C_IDLE, 0, 0, 0, 16'd0);
`else
    ir = 8'h14; bus = 8'h00; alu_carry = 1'b0;
    cyc("ss_idle", C_IDLE, 0, 0, 0, 16'd0);
    cyc("ss_fetch1", C_FETCH, 0, 0, 0, 16'd0);
    cyc("ss_exec1", 14'b0010000_1011_010, 0, 0, 0, 16'd0);
    cyc("ss_pause1a", C_IDLE, 1, 0, 0, 16'd1);
    cyc("ss_pause1b", C_IDLE, 1, 0, 0, 16'd1);
    step = 1'b1;
    cyc("ss_pause1_step", C_IDLE, 1, 0, 0, 16'd1);
    cyc("ss_fetch2", C_FETCH, 1, 0, 0, 16'd1);
    cyc("ss_exec2", 14'b0010000_1011_010, 1, 0, 0, 16'd1);
    cyc("ss_pause2_held", C_IDLE, 1, 0, 0, 16'd2);
    step = 1'b0;
    cyc("ss_pause2_low", C_IDLE, 1, 0, 0, 16'd2);
    step = 1'b1;
    cyc("ss_pause2_step", C_IDLE, 1, 0, 0, 16'd2);
    ir = 8'h0E;
    cyc("ss_fetch3", C_FETCH, 1, 0, 0, 16'd2);
    cyc("ss_exec3_halt", 14'b0000000_0111_010, 1, 0, 0, 16'd2);
    step = 1'b0;
    cyc("ss_halt", C_IDLE, 1, 0, 1, 16'd3);
    step = 1'b1;
    cyc("ss_halt_step_ignored", C_IDLE, 1, 0, 1, 16'd3);
`endif

    assertions++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain: observed %0d required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
